// File: rtl/nn_job_sequencer.sv
// Issues queued inference jobs to nn_accelerator_top: FIFO of operand sets,
// start/done handshake with timeout, and a held valid/ready result slot.
`timescale 1ns/1ps
module nn_job_sequencer #(
  parameter int DATA_W  = 8,
  parameter int BIAS_W  = 32,
  parameter int SCALE_W = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [DATA_W-1:0]        job_act,
  input  logic [DATA_W-1:0]        job_wt,
  input  logic [BIAS_W-1:0]        job_bias,
  input  logic [SCALE_W-1:0]       job_scale,
  output logic                     acc_start,
  output logic [DATA_W-1:0]        acc_act,
  output logic [DATA_W-1:0]        acc_wt,
  output logic [BIAS_W-1:0]        acc_bias,
  output logic [SCALE_W-1:0]       acc_scale,
  input  logic [DATA_W-1:0]        acc_out,
  input  logic                     acc_done,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W-1:0]        res_data,
  output logic                     res_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   job_count,
  output logic [15:0]              jobs_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int JW = 2*DATA_W + BIAS_W + SCALE_W;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [JW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [TW-1:0]   timer;
  logic            push, pop;
  logic            capture, cap_err;
  logic            timer_clr, timer_inc;

  // Ready depends only on occupancy, so a full FIFO refuses a push even while popping.
  assign job_ready = (job_count != CW'(DEPTH));
  assign push      = job_valid && job_ready;
  assign acc_start = (state == ISSUE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {job_act, job_wt, job_bias, job_scale};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      job_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      job_count <= job_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // acc_done is only meaningful in WAIT; IDLE and ISSUE never look at it.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    cap_err   = 1'b0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if ((job_count != '0) && (!res_valid || res_ready)) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        timer_clr = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (acc_done) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (timer == TIMER_LAST) begin
          capture   = 1'b1;
          cap_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (timer_clr) begin
      timer <= '0;
    end else if (timer_inc) begin
      timer <= timer + TW'(1);
    end
  end

  // Operands stay put from ISSUE until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_act   <= '0;
      acc_wt    <= '0;
      acc_bias  <= '0;
      acc_scale <= '0;
    end else if (pop) begin
      {acc_act, acc_wt, acc_bias, acc_scale} <= mem[rd_ptr];
    end
  end

  // A capture in the same cycle as a consumer handshake keeps the slot full.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      jobs_done <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_data  <= cap_err ? '0 : acc_out;
      res_err   <= cap_err;
      jobs_done <= jobs_done + 16'd1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
